// File: rtl/mac_accum.sv
// mac_accum: burst multiply-accumulate with a registered product stage.
// Optional build macro: MAC_ACCUM_SAT_EN. When it is defined, overflowing adds
// clamp to the signed ACC_W limits. When it is undefined, adds wrap.
// The ovf flag is sticky per burst in both builds.
module mac_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic signed [15:0]       prod_q, prod_d;
  logic                     pvld_q, pvld_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic                     ovf_q, ovf_d;

  logic signed [7:0]        xs, ys;
  logic [ACC_W:0]           sum;
  logic                     add_ovf;
  logic                     accept, last;

  // The sum is computed one bit wider than acc so that overflow can be seen.
  // Overflow has occurred when the top two bits of the wide sum disagree.
  always_comb begin
    xs      = x;
    ys      = y;
    accept  = (state_q == RUN) && in_valid;
    last    = accept && (cnt_q == (len_q - LEN_W'(1)));
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){prod_q[15]}}, prod_q};
    add_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  end

  // Next-state logic covers three things: the product stage, the accumulate
  // stage and the burst FSM. A start in IDLE clears acc and ovf, and this
  // clear is applied after the accumulate update.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    pvld_d  = accept;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    if (accept) prod_d = xs * ys;

    if (pvld_q) begin
      ovf_d = ovf_q | add_ovf;
`ifdef MAC_ACCUM_SAT_EN
      if (add_ovf) acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
      else         acc_d = sum[ACC_W-1:0];
`else
      acc_d = sum[ACC_W-1:0];
`endif
    end

    case (state_q)
      IDLE: if (start) begin
        acc_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
        if (len != '0) begin
          len_d   = len;
          state_d = RUN;
        end else begin
          state_d = DONE;
        end
      end
      RUN: if (accept) begin
        cnt_d = cnt_q + LEN_W'(1);
        if (last) state_d = DRAIN;
      end
      // The last product gets added in this cycle, so DONE follows next.
      DRAIN: if (pvld_q) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset has priority and discards any product in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      pvld_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      pvld_q  <= pvld_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: directed bursts with hand-computed results. A scoreboard queue
// is filled by the stimulus and drained by a monitor on result handshakes.
module tb_mac_accum;
  localparam int ACC_W = 17;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, out_ready;
  logic [LEN_W-1:0] len;
  logic [7:0]       x, y;
  logic             in_ready, out_valid, ovf;
  logic [ACC_W-1:0] acc;

  typedef struct { int a; bit o; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  mac_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .x(x), .y(y),
    .in_valid(in_valid), .in_ready(in_ready), .acc(acc),
    .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic int acc_i();
    return int'($signed(acc));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare on every result handshake.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_acc", acc_i(), e.a);
        chk("sb_ovf", int'(ovf), int'(e.o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
  endtask

  // Present one pair and hold it until it is accepted, giving up after a bounded number of cycles.
  task automatic send(input int a, input int b);
    bit ok;
    ok = 1'b0;
    x = 8'(a);
    y = 8'(b);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Call right after the last accept. Checks T+1 and T+2, then takes the result.
  task automatic finish_burst(input string tag);
    @(negedge clk);
    chk({tag, "_ov_t1"}, int'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_ov_t2"}, int'(out_valid), 1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_idle"}, int'(out_valid), 0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; len = '0; x = '0; y = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_acc", acc_i(), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_ir", int'(in_ready), 0);
    tick();

    // Basic burst: the expected sum is 105 + 8300 - 8300 = 105.
    e.a = 105; e.o = 1'b0; sb.push_back(e);
    do_start(3);
    x = 8'd15; y = 8'd7; in_valid = 1'b1; tick();
    x = 8'd100; y = 8'd83; tick();
    x = 8'(-100); y = 8'd83; tick();
    in_valid = 1'b0;
    finish_burst("basic");
    chk("idle_hold_acc", acc_i(), 105);

    // Corner operands: products of -128 with other negatives.
    e.a = 44928; e.o = 1'b0; sb.push_back(e);
    do_start(4);
    send(-128, -66); send(-128, -114); send(-128, -50); send(-128, -121);
    finish_burst("corner");

    // Overflow with five products of 16384 at ACC_W=17.
`ifdef MAC_ACCUM_SAT_EN
    e.a = 65535;
`else
    e.a = -49152;
`endif
    e.o = 1'b1; sb.push_back(e);
    do_start(5);
    for (int i = 0; i < 5; i++) send(-128, -128);
    finish_burst("ovf");
    chk("ovf_sticky_idle", int'(ovf), 1);

    // Handshakes: in_valid toggles, and DONE is held with start pulsed.
    e.a = -2093; e.o = 1'b0; sb.push_back(e);
    do_start(2);
    x = 8'd52; y = 8'(-41); in_valid = 1'b1; tick();
    x = 8'd99; y = 8'd99; in_valid = 1'b0; tick();
    x = 8'(-3); y = 8'(-13); in_valid = 1'b1; tick();
    in_valid = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = LEN_W'(3);
      @(negedge clk);
      chk("hs_ov_hold", int'(out_valid), 1);
      chk("hs_acc_hold", acc_i(), -2093);
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    chk("hs_start_ignored", int'(in_ready), 0);
    tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    @(negedge clk);
    chk("hs_ov_idle", int'(out_valid), 0);
    tick();

    // Reset during RUN, followed by a zero-length burst.
    do_start(3);
    send(15, 7);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_acc", acc_i(), 0);
    chk("mrst_ovf", int'(ovf), 0);
    chk("mrst_ov", int'(out_valid), 0);
    chk("mrst_ir", int'(in_ready), 0);
    tick();
    e.a = 0; e.o = 1'b0; sb.push_back(e);
    do_start(0);
    @(negedge clk);
    chk("len0_ov", int'(out_valid), 1);
    chk("len0_acc", acc_i(), 0);
    tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) chk("sb_drain_timeout", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_accum.md
MAC_ACCUM -- requirements
Module: mac_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24: accumulator width in bits, signed, minimum 17.
REQ-002 The block SHALL have parameter LEN_W, default 8: width of the burst-length input.
REQ-003 Port clk SHALL be input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port start SHALL be input, 1 bit: begin-burst pulse, sampled only in IDLE.
REQ-006 Port len SHALL be input, LEN_W bits: number of operand pairs in the burst, unsigned, latched on start.
REQ-007 Port x SHALL be input, 8 bits: signed operand.
REQ-008 Port y SHALL be input, 8 bits: signed operand.
REQ-009 Port in_valid SHALL be input, 1 bit: x and y are valid.
REQ-010 Port in_ready SHALL be output, 1 bit: block accepts an operand pair.
REQ-011 Port acc SHALL be output, ACC_W bits: signed running and final sum.
REQ-012 Port out_valid SHALL be output, 1 bit: acc holds the final burst result.
REQ-013 Port out_ready SHALL be input, 1 bit: consumer takes the result.
REQ-014 Port ovf SHALL be output, 1 bit: sticky overflow flag for the current burst.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE with start=1 and len>0, the block SHALL latch len, clear acc, ovf and the pair counter, and enter RUN.
REQ-017 In IDLE with start=1 and len=0, the block SHALL clear acc and ovf and enter DONE directly.
REQ-018 The block SHALL ignore start in every state except IDLE.
REQ-019 in_ready SHALL be 1 only in RUN; a pair is accepted in any cycle where in_valid and in_ready are both 1.
REQ-020 Each accepted pair SHALL be multiplied to the exact 16-bit signed product, including x=-128 and y=-128, and registered in a product stage together with a valid bit.
REQ-021 One cycle after the product is registered, the block SHALL add the sign-extended product to acc.
REQ-022 When the len-th pair is accepted, the block SHALL leave RUN for DRAIN in the next cycle and drop in_ready.
REQ-023 DRAIN SHALL last until the last product has been added to acc, then the block SHALL enter DONE.
REQ-024 Latency: if the last pair is accepted in cycle T, out_valid SHALL be 1 in cycle T+2.
REQ-025 In DONE, out_valid SHALL be 1 and acc and ovf SHALL stay stable until out_ready=1.
REQ-026 A cycle in DONE with out_ready=1 SHALL return the block to IDLE, with out_valid=0 from the next cycle.
REQ-027 acc and ovf SHALL keep their final values in IDLE until the next accepted start.
REQ-028 in_valid gaps in RUN SHALL only stall the counter; they SHALL NOT change acc beyond the add of a product already in flight.
REQ-029 An add whose exact result falls outside the signed ACC_W range SHALL set ovf, which stays set until the next start.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-031 On reset, acc=0, ovf=0, out_valid=0, in_ready=0, and the product valid bit and pair counter SHALL be cleared.
REQ-032 Reset SHALL take priority over all other inputs, including a reset in the middle of RUN or DRAIN, which discards the in-flight product.

Configuration
REQ-033 With the macro MAC_ACCUM_SAT_EN defined, an overflowing add SHALL clamp acc to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and further adds SHALL saturate.
REQ-034 With MAC_ACCUM_SAT_EN undefined, acc SHALL wrap modulo 2^ACC_W; ovf SHALL behave per REQ-029 in both builds.

Verification
REQ-035 Basic burst: len=3, pairs (15,7), (100,83), (-100,83) with in_valid held high -> acc=105, ovf=0, out_valid exactly 2 cycles after the third pair is accepted.
REQ-036 Corner operands: len=4, pairs (-128,-66), (-128,-114), (-128,-50), (-128,-121) -> acc=8448+14592+6400+15488=44928, ovf=0.
REQ-037 Overflow with ACC_W=17: len=5, each pair (-128,-128), i.e. five products of 16384 -> with MAC_ACCUM_SAT_EN acc=65535 and ovf=1; without it acc=-49152 and ovf=1.
REQ-038 Handshakes: len=2, in_valid toggling every cycle, out_ready held low for 5 cycles in DONE -> acc=(52*-41)+(-3*-13)=-2093, held stable, out_valid high throughout, and start ignored during DONE.
REQ-039 Resets: rst pulsed after 1 of 3 pairs in RUN -> next cycle all outputs are at reset values; then start with len=0 -> out_valid=1 one cycle later with acc=0.
